// File: rtl/if_fetch_unit.sv
// IF-stage PC sequencer and instruction-fetch controller.
// Keeps one memory request in flight and hands {pc, inst} to decode through a one-entry slot.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   // predictor interface
   output logic [31:0] if_pc,
   input  logic [31:0] pred_target,
   // EX-stage redirect
   input  logic        pred_error,
   input  logic [31:0] ex_pc,
   input  logic        real_taken,
   input  logic [31:0] real_target,
   // decode stall
   input  logic        suspend,
   // instruction memory
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic        inst_rvalid,
   input  logic [31:0] inst_rdata,
   // decode slot
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_inst
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        cancel_q, cancel_d;
   logic        redir_pend_q, redir_pend_d;
   logic        dec_valid_q, dec_valid_d;
   logic [31:0] dec_pc_q, dec_pc_d;
   logic [31:0] dec_inst_q, dec_inst_d;

   logic        redir;
   logic [31:0] corr_pc;
   logic        drain;
   logic        slot_free;
   logic        deliver;

   assign redir     = pred_error;
   assign corr_pc   = real_taken ? real_target : ex_pc + 32'd4;
   assign drain     = dec_valid_q && !suspend;
   assign slot_free = !dec_valid_q || drain;

   // ---------------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (redir || slot_free) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (inst_ack) begin
               state_d = StWait;
            end
         end
         StWait: begin
            // A dropped response goes straight back to fetch the corrected path.
            if (inst_rvalid) begin
               state_d = (cancel_q || redir) ? StReq : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      inst_req = 1'b0;
      unique case (state_q)
         StReq:   inst_req = 1'b1;
         default: inst_req = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // PC sequencing and redirect bookkeeping
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      redir_pc_d   = redir_pc_q;
      cancel_d     = cancel_q;
      redir_pend_d = redir_pend_q;
      deliver      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (redir) begin
               pc_d = corr_pc;
            end
         end
         StReq: begin
            if (inst_ack) begin
               req_pc_d = pc_q;
               if (redir || redir_pend_q) begin
                  // The accepted request is wrong-path; its response must be dropped.
                  pc_d         = redir ? corr_pc : redir_pc_q;
                  cancel_d     = 1'b1;
                  redir_pend_d = 1'b0;
               end else begin
                  pc_d = pred_target;
               end
            end else if (redir) begin
               // Address must stay stable until ack, so park the latest corrected PC.
               redir_pc_d   = corr_pc;
               redir_pend_d = 1'b1;
            end
         end
         StWait: begin
            if (inst_rvalid) begin
               if (cancel_q || redir) begin
                  cancel_d = 1'b0;
                  if (redir) begin
                     pc_d = corr_pc;
                  end
               end else begin
                  deliver = 1'b1;
               end
            end else if (redir) begin
               pc_d     = corr_pc;
               cancel_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'd0;
         redir_pc_q   <= 32'd0;
         cancel_q     <= 1'b0;
         redir_pend_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         redir_pc_q   <= redir_pc_d;
         cancel_q     <= cancel_d;
         redir_pend_q <= redir_pend_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Decode output slot; a flush takes priority over a stall
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      dec_valid_d = dec_valid_q;
      dec_pc_d    = dec_pc_q;
      dec_inst_d  = dec_inst_q;
      if (redir) begin
         dec_valid_d = 1'b0;
      end else if (deliver) begin
         dec_valid_d = 1'b1;
         dec_pc_d    = req_pc_q;
         dec_inst_d  = inst_rdata;
      end else if (drain) begin
         dec_valid_d = 1'b0;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         dec_valid_q <= 1'b0;
         dec_pc_q    <= 32'd0;
         dec_inst_q  <= 32'd0;
      end else begin
         dec_valid_q <= dec_valid_d;
         dec_pc_q    <= dec_pc_d;
         dec_inst_q  <= dec_inst_d;
      end
   end

   assign if_pc     = pc_q;
   assign inst_addr = pc_q;
   assign dec_valid = dec_valid_q;
   assign dec_pc    = dec_pc_q;
   assign dec_inst  = dec_inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by randomized traffic checked against
// an instruction-stream model (predictor function, memory contents, redirect rules).
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] if_pc;
   logic [31:0] pred_target;
   logic        pred_error;
   logic [31:0] ex_pc;
   logic        real_taken;
   logic [31:0] real_target;
   logic        suspend;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;

   int checks   = 0;
   int failures = 0;

   logic        use_fixed;
   logic [31:0] fixed_pred;

   if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .if_pc       (if_pc),
      .pred_target (pred_target),
      .pred_error  (pred_error),
      .ex_pc       (ex_pc),
      .real_taken  (real_taken),
      .real_target (real_target),
      .suspend     (suspend),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_ack    (inst_ack),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .dec_valid   (dec_valid),
      .dec_pc      (dec_pc),
      .dec_inst    (dec_inst)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Toy predictor: some PCs predicted taken forward, the rest fall through.
   function automatic logic [31:0] pred_fn(input logic [31:0] a);
      return (a[5:2] == 4'hb) ? a + 32'h40 : a + 32'd4;
   endfunction

   // Memory contents: a distinct word per address.
   function automatic logic [31:0] data_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3c5a_0f0f;
   endfunction

   always_comb pred_target = use_fixed ? fixed_pred : pred_fn(if_pc);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic do_reset();
      cpu_rst     = 1'b1;
      pred_error  = 1'b0;
      inst_ack    = 1'b0;
      inst_rvalid = 1'b0;
      suspend     = 1'b0;
      tick();
      tick();
      cpu_rst = 1'b0;
   endtask

   logic [31:0] mem_q[$];
   int          resp_wait;
   logic [31:0] exp_next, corr, hold_pc, hold_inst, ack_addr, prev_addr;
   logic        hold, flush, ack_now, rv_now, prev_req, prev_ack;
   int          consumed;

   initial begin
      cpu_rst     = 1'b1;
      pred_error  = 1'b0;
      ex_pc       = 32'd0;
      real_taken  = 1'b0;
      real_target = 32'd0;
      suspend     = 1'b0;
      inst_ack    = 1'b0;
      inst_rvalid = 1'b0;
      inst_rdata  = 32'd0;
      use_fixed   = 1'b1;
      fixed_pred  = 32'd0;

      // T1 reset
      tick();
      tick();
      chk("rst_req", inst_req, 1'b0);
      chk("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_pc", if_pc, RESET_PC);
      cpu_rst = 1'b0;
      tick();
      chk("t1_req", inst_req, 1'b1);
      chk("t1_addr", inst_addr, RESET_PC);

      // T2 sequential fetch
      fixed_pred = 32'h1c00_0004;
      inst_ack   = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("t2_wait_req", inst_req, 1'b0);
      inst_rvalid = 1'b1;
      inst_rdata  = 32'h0280_0000;
      tick();
      inst_rvalid = 1'b0;
      chk("t2_dec_valid", dec_valid, 1'b1);
      chk("t2_dec_pc", dec_pc, 32'h1c00_0000);
      chk("t2_dec_inst", dec_inst, 32'h0280_0000);
      tick();
      chk("t2_drained", dec_valid, 1'b0);
      chk("t2_next_req", inst_req, 1'b1);
      chk("t2_next_addr", inst_addr, 32'h1c00_0004);

      // T3 predicted taken
      fixed_pred = 32'h1c00_0100;
      inst_ack   = 1'b1;
      tick();
      inst_ack    = 1'b0;
      inst_rvalid = 1'b1;
      inst_rdata  = 32'h0000_1111;
      tick();
      inst_rvalid = 1'b0;
      chk("t3_dec_pc", dec_pc, 32'h1c00_0004);
      tick();
      chk("t3_next_addr", inst_addr, 32'h1c00_0100);

      // T4 redirect in WAIT
      fixed_pred = 32'h1c00_0104;
      inst_ack   = 1'b1;
      tick();
      inst_ack    = 1'b0;
      pred_error  = 1'b1;
      real_taken  = 1'b1;
      real_target = 32'h1c00_0200;
      ex_pc       = 32'h1c00_0080;
      tick();
      pred_error = 1'b0;
      chk("t4_pc", if_pc, 32'h1c00_0200);
      inst_rvalid = 1'b1;
      inst_rdata  = 32'hbad0_0001;
      tick();
      inst_rvalid = 1'b0;
      chk("t4_dropped", dec_valid, 1'b0);
      chk("t4_req", inst_req, 1'b1);
      chk("t4_addr", inst_addr, 32'h1c00_0200);

      // T5 redirect in REQ with delayed ack
      pred_error = 1'b1;
      ex_pc      = 32'h1c00_0040;
      real_taken = 1'b0;
      tick();
      pred_error = 1'b0;
      chk("t5_hold1", inst_addr, 32'h1c00_0200);
      chk("t5_req1", inst_req, 1'b1);
      tick();
      chk("t5_hold2", inst_addr, 32'h1c00_0200);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("t5_pc", if_pc, 32'h1c00_0044);
      inst_rvalid = 1'b1;
      inst_rdata  = 32'hbad0_0002;
      tick();
      inst_rvalid = 1'b0;
      chk("t5_dropped", dec_valid, 1'b0);
      chk("t5_addr", inst_addr, 32'h1c00_0044);

      // T6 stall then flush; spurious ack/rvalid in IDLE are ignored
      fixed_pred = 32'h1c00_0048;
      inst_ack   = 1'b1;
      tick();
      inst_ack    = 1'b0;
      inst_rvalid = 1'b1;
      inst_rdata  = 32'h1122_3344;
      suspend     = 1'b1;
      tick();
      chk("t6_s1_valid", dec_valid, 1'b1);
      chk("t6_s1_pc", dec_pc, 32'h1c00_0044);
      chk("t6_s1_inst", dec_inst, 32'h1122_3344);
      inst_ack   = 1'b1;
      inst_rdata = 32'hdead_beef;
      tick();
      inst_ack    = 1'b0;
      inst_rvalid = 1'b0;
      chk("t6_s2_valid", dec_valid, 1'b1);
      chk("t6_s2_inst", dec_inst, 32'h1122_3344);
      chk("t6_s2_req", inst_req, 1'b0);
      tick();
      chk("t6_s3_pc", dec_pc, 32'h1c00_0044);
      pred_error  = 1'b1;
      real_taken  = 1'b1;
      real_target = 32'h1c00_0300;
      tick();
      pred_error = 1'b0;
      chk("t6_flush", dec_valid, 1'b0);
      chk("t6_req", inst_req, 1'b1);
      chk("t6_addr", inst_addr, 32'h1c00_0300);
      suspend = 1'b0;

      // Randomized traffic against the stream model
      use_fixed = 1'b0;
      do_reset();
      mem_q.delete();
      resp_wait = 0;
      exp_next  = RESET_PC;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      prev_addr = 32'd0;
      consumed  = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 2000) begin
            do_reset();
            mem_q.delete();
            resp_wait = 0;
            exp_next  = RESET_PC;
            prev_req  = 1'b0;
         end
         if (inst_req && prev_req && !prev_ack) chk("addr_stable", inst_addr, prev_addr);
         suspend     = ($urandom_range(0, 9) < 3);
         pred_error  = ($urandom_range(0, 19) == 0);
         real_taken  = 1'($urandom_range(0, 1));
         real_target = 32'h1c00_0000 | ($urandom & 32'h000f_fffc);
         ex_pc       = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc
                                                   : (32'h1c00_0000 | ($urandom & 32'h000f_fffc));
         inst_ack    = inst_req && ($urandom_range(0, 1) == 1);
         corr        = real_taken ? real_target : ex_pc + 32'd4;
         if (dec_valid && !suspend && !pred_error) begin
            chk("dec_pc", dec_pc, exp_next);
            chk("dec_inst", dec_inst, data_fn(dec_pc));
            exp_next = pred_fn(dec_pc);
            consumed++;
         end
         if (pred_error) exp_next = corr;
         hold      = dec_valid && suspend && !pred_error;
         hold_pc   = dec_pc;
         hold_inst = dec_inst;
         flush     = pred_error;
         ack_now   = inst_ack;
         rv_now    = inst_rvalid;
         ack_addr  = inst_addr;
         prev_req  = inst_req;
         prev_ack  = inst_ack;
         prev_addr = inst_addr;
         tick();
         if (flush) chk("flush", dec_valid, 1'b0);
         if (hold) begin
            chk("stall_valid", dec_valid, 1'b1);
            chk("stall_pc", dec_pc, hold_pc);
            chk("stall_inst", dec_inst, hold_inst);
         end
         if (rv_now && mem_q.size() != 0) void'(mem_q.pop_front());
         if (ack_now) begin
            mem_q.push_back(ack_addr);
            resp_wait = $urandom_range(0, 2);
         end
         inst_rvalid = 1'b0;
         if (mem_q.size() != 0) begin
            if (resp_wait == 0) begin
               inst_rvalid = 1'b1;
               inst_rdata  = data_fn(mem_q[0]);
            end else begin
               resp_wait--;
            end
         end
      end
      chk("progress", 32'(consumed >= 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
